vga_scan_ctrl: RTL and testbench

Raster scan controller for the 640x480@60 Hz display path. It derives a one-cycle pixel-rate enable from the 100 MHz system clock and sequences horizontal and vertical counters through the active, front-porch, sync and back-porch phases. It drives the monitor's `hsync`/`vsync` and tells the game renderer and framebuffer which pixel is currently being scanned. All logic runs on `clk`; no derived clock is produced.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_scan_ctrl_pix_tick.sv | 30 +++
 rtl/vga_scan_ctrl.sv | 119 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default timing for the 640x480@60 raster path.
// Holds scan phase encodings and the sync polarity.
package vga_pkg;

   typedef enum logic [1:0] {
      H_ACTV,
      H_FRNT,
      H_SYNC,
      H_BACK
   } h_state_t;

   typedef enum logic [1:0] {
      V_ACTV,
      V_FRNT,
      V_SYNC,
      V_BACK
   } v_state_t;

   localparam int DEF_DIV   = 4;
   localparam int DEF_H_ACT = 640;
   localparam int DEF_H_FP  = 16;
   localparam int DEF_H_SYN = 96;
   localparam int DEF_H_BP  = 48;
   localparam int DEF_V_ACT = 480;
   localparam int DEF_V_FP  = 10;
   localparam int DEF_V_SYN = 2;
   localparam int DEF_V_BP  = 33;

   localparam int H_TOT =
      DEF_H_ACT + DEF_H_FP + DEF_H_SYN + DEF_H_BP;
   localparam int V_TOT =
      DEF_V_ACT + DEF_V_FP + DEF_V_SYN + DEF_V_BP;

   localparam logic SYNC_ACT = 1'b0;

endpackage

// File: rtl/vga_scan_ctrl_pix_tick.sv
// Pixel-rate enable: divides clk by DIV, gated by en.
// Also reused by the game-logic tick generator.
module pix_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic pix_en
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] div;

   // divider advances only while running; pulse follows the last count
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else if (en) begin
         pix_en <= (div == LAST);
         div    <= (div == LAST) ? '0 : W'(div + 1'b1);
      end else begin
         pix_en <= 1'b0;
      end
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster scan controller: H/V phase machines, counters,
// and registered sync/video outputs aligned with the counters.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int DIV   = DEF_DIV,
   parameter int H_ACT = DEF_H_ACT,
   parameter int H_FP  = DEF_H_FP,
   parameter int H_SYN = DEF_H_SYN,
   parameter int H_BP  = DEF_H_BP,
   parameter int V_ACT = DEF_V_ACT,
   parameter int V_FP  = DEF_V_FP,
   parameter int V_SYN = DEF_V_SYN,
   parameter int V_BP  = DEF_V_BP
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   output logic       pix_en,
   output logic [9:0] hcnt,
   output logic [9:0] vcnt,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start
);

   localparam logic [9:0] H_E0 = 10'(H_ACT - 1);
   localparam logic [9:0] H_E1 = 10'(H_ACT + H_FP - 1);
   localparam logic [9:0] H_E2 = 10'(H_ACT + H_FP + H_SYN - 1);
   localparam logic [9:0] H_E3 =
      10'(H_ACT + H_FP + H_SYN + H_BP - 1);
   localparam logic [9:0] V_E0 = 10'(V_ACT - 1);
   localparam logic [9:0] V_E1 = 10'(V_ACT + V_FP - 1);
   localparam logic [9:0] V_E2 = 10'(V_ACT + V_FP + V_SYN - 1);
   localparam logic [9:0] V_E3 =
      10'(V_ACT + V_FP + V_SYN + V_BP - 1);

   h_state_t   h_st, h_nxt;
   v_state_t   v_st, v_nxt;
   logic [9:0] hcnt_nxt, vcnt_nxt;
   logic       step, h_wrap, v_wrap;

   pix_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .clr    (clr),
      .en     (en),
      .pix_en (pix_en)
   );

   assign step   = pix_en & en;
   assign h_wrap = (hcnt == H_E3);
   assign v_wrap = (vcnt == V_E3);

   // next position and phase; only moves on a pixel tick
   always_comb begin
      h_nxt    = h_st;
      v_nxt    = v_st;
      hcnt_nxt = hcnt;
      vcnt_nxt = vcnt;
      if (step) begin
         hcnt_nxt = h_wrap ? '0 : hcnt + 10'd1;
         unique case (h_st)
            H_ACTV: if (hcnt == H_E0) h_nxt = H_FRNT;
            H_FRNT: if (hcnt == H_E1) h_nxt = H_SYNC;
            H_SYNC: if (hcnt == H_E2) h_nxt = H_BACK;
            H_BACK: if (hcnt == H_E3) h_nxt = H_ACTV;
            default: h_nxt = H_ACTV;
         endcase
         if (h_wrap) begin
            vcnt_nxt = v_wrap ? '0 : vcnt + 10'd1;
            unique case (v_st)
               V_ACTV: if (vcnt == V_E0) v_nxt = V_FRNT;
               V_FRNT: if (vcnt == V_E1) v_nxt = V_SYNC;
               V_SYNC: if (vcnt == V_E2) v_nxt = V_BACK;
               V_BACK: if (vcnt == V_E3) v_nxt = V_ACTV;
               default: v_nxt = V_ACTV;
            endcase
         end
      end
   end

   // phase and position registers
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         h_st <= H_ACTV;
         v_st <= V_ACTV;
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         h_st <= h_nxt;
         v_st <= v_nxt;
         hcnt <= hcnt_nxt;
         vcnt <= vcnt_nxt;
      end
   end

   // outputs decoded from next phase so they line up with the counters
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hsync       <= ~SYNC_ACT;
         vsync       <= ~SYNC_ACT;
         video_on    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (en) begin
         hsync       <= (h_nxt == H_SYNC) ? SYNC_ACT : ~SYNC_ACT;
         vsync       <= (v_nxt == V_SYNC) ? SYNC_ACT : ~SYNC_ACT;
         video_on    <= (h_nxt == H_ACTV) && (v_nxt == V_ACTV);
         line_start  <= step & h_wrap;
         frame_start <= step & h_wrap & v_wrap;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl with a reduced raster geometry.
// Reference model feeds a queue compared every falling edge.
module tb_vga_scan_ctrl;

   localparam int DIV = 4;
   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       en  = 1'b1;
   logic       pix_en, hsync, vsync, video_on;
   logic       line_start, frame_start;
   logic [9:0] hcnt, vcnt;

   int n_chk  = 0;
   int n_fail = 0;

   vga_scan_ctrl #(
      .DIV(DIV), .H_ACT(HA), .H_FP(HF), .H_SYN(HS), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYN(VS), .V_BP(VB)
   ) dut (
      .clk         (clk),
      .clr         (clr),
      .en          (en),
      .pix_en      (pix_en),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // reference model
   int   m_div, mh, mv;
   logic m_pix, m_hs, m_vs, m_von, m_ls, m_fs, stp;
   logic [25:0] sb_q[$];

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         m_div = 0; mh = 0; mv = 0; m_pix = 0;
         m_hs = 1; m_vs = 1; m_von = 0; m_ls = 0; m_fs = 0;
         sb_q.delete();
      end else if (en) begin
         stp   = m_pix;
         m_pix = (m_div == DIV - 1);
         m_div = (m_div + 1) % DIV;
         m_ls  = stp && (mh == HT - 1);
         m_fs  = m_ls && (mv == VT - 1);
         if (stp) begin
            if (mh == HT - 1) begin
               mh = 0;
               mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
               mh = mh + 1;
            end
         end
         m_hs  = !(mh >= HA + HF && mh < HA + HF + HS);
         m_vs  = !(mv >= VA + VF && mv < VA + VF + VS);
         m_von = (mh < HA) && (mv < VA);
      end else begin
         m_pix = 0; m_ls = 0; m_fs = 0;
      end
      sb_q.push_back({m_pix, 10'(mh), 10'(mv),
                      m_hs, m_vs, m_von, m_ls, m_fs});
   end

   logic [25:0] sb_e;
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         sb_e = sb_q.pop_front();
         check("scan",
               {6'd0, pix_en, hcnt, vcnt, hsync, vsync,
                video_on, line_start, frame_start},
               {6'd0, sb_e});
      end
   end

   int k, cnt, hl, vl, vo, h_first, v_fall;
   logic bad;
   logic [25:0] snap;

   initial begin
      // reset and first tick latency
      repeat (5) @(posedge clk);
      #1;
      check("rst_hcnt", 32'(hcnt), 0);
      check("rst_vcnt", 32'(vcnt), 0);
      check("rst_sync", {30'd0, hsync, vsync}, 3);
      check("rst_von", 32'(video_on), 0);
      @(negedge clk);
      clr = 1'b0;
      for (k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (k == 1) check("von_first", 32'(video_on), 1);
         if (pix_en) break;
      end
      check("first_pix", k, DIV);

      // one line: hsync width and video_on fall point
      k = 0;
      do begin @(posedge clk); #1; k++; end
      while (!line_start && k < 200);
      check("ls_seen", 32'(line_start), 1);
      hl = 0; h_first = -1; v_fall = -1;
      for (int i = 0; i < HT * DIV; i++) begin
         @(posedge clk); #1;
         if (!hsync) begin
            hl++;
            if (h_first < 0) h_first = hcnt;
         end
         if (!video_on && v_fall < 0) v_fall = hcnt;
      end
      check("hs_width", hl, HS * DIV);
      check("hs_start", h_first, HA + HF);
      check("von_fall", v_fall, HA);

      // three frames
      k = 0;
      do begin @(posedge clk); #1; k++; end
      while (!frame_start && k < 1000);
      check("fs_seen", 32'(frame_start), 1);
      for (int f = 0; f < 3; f++) begin
         cnt = 0; vl = 0; vo = 0;
         do begin
            @(posedge clk); #1; cnt++;
            if (!vsync) vl++;
            if (video_on) vo++;
         end while (!frame_start && cnt < 1000);
         check("frame_len", cnt, HT * VT * DIV);
         check("vs_width", vl, VS * HT * DIV);
         check("von_pix", vo / DIV, HA * VA);
         check("fs_ls", 32'(line_start), 1);
         check("fs_pos", {hcnt, vcnt}, 0);
      end

      // freeze in the middle of hsync
      k = 0;
      do begin @(posedge clk); #1; k++; end
      while (hcnt != 10'(HA + HF + HS - 1) && k < 200);
      check("frz_pos", 32'(hcnt), HA + HF + HS - 1);
      en = 1'b0;
      snap = {pix_en, hcnt, vcnt, hsync, vsync, video_on,
              line_start, frame_start};
      bad = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if ({hcnt, vcnt, hsync, vsync, video_on} !== snap[24:2])
            bad = 1'b1;
         if (pix_en | line_start | frame_start) bad = 1'b1;
      end
      check("frz_hold", 32'(bad), 0);
      en = 1'b1;
      for (k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (pix_en) break;
      end
      check("frz_resume", k, DIV - 1);
      @(posedge clk); #1;
      check("frz_next", 32'(hcnt), HA + HF + HS);

      // asynchronous reset inside both sync pulses
      k = 0;
      do begin @(posedge clk); #1; k++; end
      while (!(vcnt == 10'(VA + VF) &&
               hcnt == 10'(HA + HF + HS - 1)) && k < 2000);
      check("ms_pre", {30'd0, hsync, vsync}, 0);
      #1 clr = 1'b1;
      #1;
      check("ms_sync", {30'd0, hsync, vsync}, 3);
      check("ms_cnt", {hcnt, vcnt}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
